// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and output widths.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam int RELOCK_W = 8;

  // WAIT_LOCK and STABLE share one timeout window.
  function automatic logic in_lock_window(input state_t s);
    return (s == ST_WAIT_LOCK) || (s == ST_STABLE);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;

  // Stage 0 may go metastable; stage 1 gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Power-up / lock-loss sequencer for the iCE40 PLL: drives RESETB, qualifies lock,
// retries failed attempts and holds the system reset until lock is stable.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 12000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic                pll_locked,
  output logic                pll_resetb,
  output logic                sys_reset_n,
  output logic                lock_lost,
  output logic                fail,
  output logic [RELOCK_W-1:0] relock_count
);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_MAX = CNT_W'(MAX_RETRIES);

  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
    return (v == {RELOCK_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic             rst_sync_n;
  logic             lock_s;
  state_t           state;
  logic [CNT_W-1:0] rst_cnt;
  logic [CNT_W-1:0] tmo;
  logic [CNT_W-1:0] stab;
  logic [CNT_W-1:0] retry;
  logic [CNT_W-1:0] retry_inc;

  // Reset asserts asynchronously but is released on a clock edge.
  sync_2ff u_rst_sync (
    .clk   (clock_in),
    .rst_n (reset_n),
    .d     (1'b1),
    .q     (rst_sync_n)
  );

  sync_2ff u_lock_sync (
    .clk   (clock_in),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  assign retry_inc = retry + 1'b1;

  always_ff @(posedge clock_in or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state        <= ST_PLL_RST;
      pll_resetb   <= 1'b0;
      sys_reset_n  <= 1'b0;
      lock_lost    <= 1'b0;
      fail         <= 1'b0;
      relock_count <= '0;
      rst_cnt      <= '0;
      tmo          <= '0;
      stab         <= '0;
      retry        <= '0;
    end else begin
      lock_lost <= 1'b0;
      unique case (state)
        ST_PLL_RST: begin
          pll_resetb  <= 1'b0;
          sys_reset_n <= 1'b0;
          if (rst_cnt == RST_LAST) begin
            state      <= ST_WAIT_LOCK;
            pll_resetb <= 1'b1;
            rst_cnt    <= '0;
            tmo        <= '0;
            stab       <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        ST_WAIT_LOCK, ST_STABLE: begin
          // The attempt deadline wins over any lock activity on the same cycle.
          if (tmo == TMO_LAST) begin
            pll_resetb <= 1'b0;
            rst_cnt    <= '0;
            tmo        <= '0;
            stab       <= '0;
            retry      <= retry_inc;
            if (retry_inc == RETRY_MAX) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end else begin
              state <= ST_PLL_RST;
            end
          end else begin
            tmo <= tmo + 1'b1;
            if (state == ST_WAIT_LOCK) begin
              if (lock_s) begin
                state <= ST_STABLE;
                stab  <= '0;
              end
            end else if (!lock_s) begin
              state <= ST_WAIT_LOCK;
              stab  <= '0;
            end else if (stab == STAB_LAST) begin
              state       <= ST_RUN;
              sys_reset_n <= 1'b1;
              stab        <= '0;
              retry       <= '0;
            end else begin
              stab <= stab + 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state        <= ST_PLL_RST;
            pll_resetb   <= 1'b0;
            sys_reset_n  <= 1'b0;
            lock_lost    <= 1'b1;
            relock_count <= sat_inc(relock_count);
            rst_cnt      <= '0;
          end
        end

        ST_FAIL: begin
          pll_resetb  <= 1'b0;
          sys_reset_n <= 1'b0;
          fail        <= 1'b1;
        end

        default: begin
          state       <= ST_PLL_RST;
          pll_resetb  <= 1'b0;
          sys_reset_n <= 1'b0;
          rst_cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer using short cycle parameters.
module tb_pll_reset_sequencer;

  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int LTC = 50;
  localparam int MR  = 2;
  localparam int CW  = 16;

  logic       clock_in = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       pll_resetb;
  logic       sys_reset_n;
  logic       lock_lost;
  logic       fail;
  logic [7:0] relock_count;

  int checks    = 0;
  int failures  = 0;
  int ll_pulses = 0;
  int ll_base;

  always #5 clock_in = ~clock_in;

  pll_reset_sequencer #(
    .PLL_RESET_CYCLES    (PRC),
    .LOCK_STABLE_CYCLES  (LSC),
    .LOCK_TIMEOUT_CYCLES (LTC),
    .MAX_RETRIES         (MR),
    .CNT_W               (CW)
  ) dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .pll_resetb   (pll_resetb),
    .sys_reset_n  (sys_reset_n),
    .lock_lost    (lock_lost),
    .fail         (fail),
    .relock_count (relock_count)
  );

  always @(negedge clock_in) if (lock_lost === 1'b1) ll_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  // Returns one tick past the edge before the first active sequencer edge (F1 is next).
  task automatic apply_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_resetb"}, 32'(pll_resetb), 32'd0);
    check_eq({tag, "_sys"},    32'(sys_reset_n), 32'd0);
    check_eq({tag, "_ll"},     32'(lock_lost), 32'd0);
    check_eq({tag, "_fail"},   32'(fail), 32'd0);
    check_eq({tag, "_relock"}, 32'(relock_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    #2;
    check_reset_outputs("reset_state");

    // 1: power-up, lock 10 cycles after RESETB release
    apply_reset();
    tick(3);  check_eq("t1_resetb_low",  32'(pll_resetb), 32'd0);
    tick(1);  check_eq("t1_resetb_high", 32'(pll_resetb), 32'd1);
    tick(9);  pll_locked = 1'b1;
    tick(10); check_eq("t1_sys_pre",     32'(sys_reset_n), 32'd0);
    tick(1);  check_eq("t1_sys_rel",     32'(sys_reset_n), 32'd1);
    check_eq("t1_fail",   32'(fail), 32'd0);
    check_eq("t1_relock", 32'(relock_count), 32'd0);
    check_eq("t1_resetb", 32'(pll_resetb), 32'd1);

    // 4: lock loss in RUN and relock
    ll_base = ll_pulses;
    pll_locked = 1'b0;
    tick(2);  check_eq("t4_ll_early",  32'(lock_lost), 32'd0);
              check_eq("t4_sys_early", 32'(sys_reset_n), 32'd1);
    tick(1);  check_eq("t4_ll_pulse",  32'(lock_lost), 32'd1);
              check_eq("t4_sys_drop",  32'(sys_reset_n), 32'd0);
              check_eq("t4_relock",    32'(relock_count), 32'd1);
              check_eq("t4_resetb0",   32'(pll_resetb), 32'd0);
    tick(1);  check_eq("t4_ll_end",    32'(lock_lost), 32'd0);
    tick(2);  check_eq("t4_resetb_low",  32'(pll_resetb), 32'd0);
    tick(1);  check_eq("t4_resetb_high", 32'(pll_resetb), 32'd1);
    pll_locked = 1'b1;
    tick(10); check_eq("t4_sys_pre",   32'(sys_reset_n), 32'd0);
    tick(1);  check_eq("t4_sys_rel",   32'(sys_reset_n), 32'd1);
    check_eq("t4_relock_hold", 32'(relock_count), 32'd1);
    check_eq("t4_pulses", 32'(ll_pulses - ll_base), 32'd1);

    // 6b: reset asserted while in RUN
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t6_run_async");
    apply_reset();
    tick(3);  check_eq("t6_resetb_low",  32'(pll_resetb), 32'd0);
    tick(1);  check_eq("t6_resetb_high", 32'(pll_resetb), 32'd1);
    tick(8);  check_eq("t6_sys_pre",     32'(sys_reset_n), 32'd0);
    tick(1);  check_eq("t6_sys_rel",     32'(sys_reset_n), 32'd1);

    // 2: one-cycle lock drop while stab=5
    pll_locked = 1'b0;
    apply_reset();
    ll_base = ll_pulses;
    tick(4);  pll_locked = 1'b1;
    tick(6);  pll_locked = 1'b0;
    tick(1);  pll_locked = 1'b1;
    tick(4);  check_eq("t2_no_early_rel", 32'(sys_reset_n), 32'd0);
    tick(6);  check_eq("t2_sys_pre",      32'(sys_reset_n), 32'd0);
    tick(1);  check_eq("t2_sys_rel",      32'(sys_reset_n), 32'd1);
    check_eq("t2_no_pulse", 32'(ll_pulses - ll_base), 32'd0);
    check_eq("t2_relock",   32'(relock_count), 32'd0);

    // 3: never locks -> two windows then FAIL
    pll_locked = 1'b0;
    apply_reset();
    tick(3);  check_eq("t3_a1_low",   32'(pll_resetb), 32'd0);
    tick(1);  check_eq("t3_a1_high",  32'(pll_resetb), 32'd1);
    tick(49); check_eq("t3_a1_end",   32'(pll_resetb), 32'd1);
    tick(1);  check_eq("t3_a2_rst",   32'(pll_resetb), 32'd0);
              check_eq("t3_a1_nofail", 32'(fail), 32'd0);
    tick(3);  check_eq("t3_a2_low",   32'(pll_resetb), 32'd0);
    tick(1);  check_eq("t3_a2_high",  32'(pll_resetb), 32'd1);
    tick(49); check_eq("t3_a2_nofail", 32'(fail), 32'd0);
    tick(1);  check_eq("t3_fail",     32'(fail), 32'd1);
              check_eq("t3_resetb",   32'(pll_resetb), 32'd0);
              check_eq("t3_sys",      32'(sys_reset_n), 32'd0);
    pll_locked = 1'b1;
    tick(30); check_eq("t3_fail_hold",   32'(fail), 32'd1);
              check_eq("t3_resetb_hold", 32'(pll_resetb), 32'd0);
              check_eq("t3_sys_hold",    32'(sys_reset_n), 32'd0);

    // 6a: reset clears FAIL, then reset asserted during STABLE
    reset_n = 1'b0;
    #1;
    check_eq("t6_fail_clr", 32'(fail), 32'd0);
    apply_reset();
    tick(7);  check_eq("t6_stable_resetb", 32'(pll_resetb), 32'd1);
              check_eq("t6_stable_sys",    32'(sys_reset_n), 32'd0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t6_stable_async");

    // 5: fail once, lock, lose lock -> two fresh attempts before FAIL
    pll_locked = 1'b0;
    apply_reset();
    tick(4);  check_eq("t5_a1_high",   32'(pll_resetb), 32'd1);
    tick(50); check_eq("t5_a1_to",     32'(pll_resetb), 32'd0);
              check_eq("t5_a1_nofail", 32'(fail), 32'd0);
    tick(4);  check_eq("t5_a2_high",   32'(pll_resetb), 32'd1);
    pll_locked = 1'b1;
    tick(11); check_eq("t5_run",       32'(sys_reset_n), 32'd1);
    pll_locked = 1'b0;
    tick(3);  check_eq("t5_ll",        32'(lock_lost), 32'd1);
              check_eq("t5_relock",    32'(relock_count), 32'd1);
    tick(4);  check_eq("t5_b1_high",   32'(pll_resetb), 32'd1);
    tick(50); check_eq("t5_b1_to",     32'(pll_resetb), 32'd0);
              check_eq("t5_b1_nofail", 32'(fail), 32'd0);
    tick(4);  check_eq("t5_b2_high",   32'(pll_resetb), 32'd1);
    tick(49); check_eq("t5_b2_nofail", 32'(fail), 32'd0);
    tick(1);  check_eq("t5_fail",      32'(fail), 32'd1);
              check_eq("t5_fail_resetb", 32'(pll_resetb), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
